// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clk cycles.
// A pin edge reaches the FSM four clk edges after it occurs; flags a static input after TIMEOUT.
module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             static_flag,
    output logic             static_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } state_t;

    logic             r_s1, r_s2, r_s3;
    logic             r_rise, r_fall;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt_per, w_cnt_per_nxt;
    logic [CNT_W-1:0] r_cnt_hi, w_cnt_hi_nxt;
    logic [CNT_W-1:0] r_period, w_period_nxt;
    logic [CNT_W-1:0] r_high, w_high_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_static, w_static_nxt;
    logic             r_level, w_level_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;

    // Edge strobes are registered so the FSM sees a clean single-cycle event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= pwm_in;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_rise <= r_s2 & ~r_s3;
            r_fall <= ~r_s2 & r_s3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= WAIT_RISE;
            r_cnt_per <= '0;
            r_cnt_hi  <= '0;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_static  <= 1'b0;
            r_level   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt_per <= w_cnt_per_nxt;
            r_cnt_hi  <= w_cnt_hi_nxt;
            r_period  <= w_period_nxt;
            r_high    <= w_high_nxt;
            r_valid   <= w_valid_nxt;
            r_static  <= w_static_nxt;
            r_level   <= w_level_nxt;
        end
    end

    assign w_cnt_inc = (r_cnt_per == CNT_MAX) ? r_cnt_per : r_cnt_per + CNT_ONE;
    assign w_timeout = (r_cnt_per >= TO_VAL);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_per_nxt = r_cnt_per;
        w_cnt_hi_nxt  = r_cnt_hi;
        w_period_nxt  = r_period;
        w_high_nxt    = r_high;
        w_valid_nxt   = 1'b0;
        w_static_nxt  = r_static;
        w_level_nxt   = r_level;
        case (r_state)
            WAIT_RISE: begin
                // First rise only establishes the phase; nothing is published.
                if (r_rise) begin
                    w_state_nxt   = HIGH;
                    w_cnt_per_nxt = CNT_ONE;
                    w_cnt_hi_nxt  = '0;
                    w_static_nxt  = 1'b0;
                end
            end
            HIGH: begin
                if (w_timeout) begin
                    w_state_nxt   = WAIT_RISE;
                    w_cnt_per_nxt = '0;
                    w_cnt_hi_nxt  = '0;
                    w_period_nxt  = '0;
                    w_high_nxt    = '0;
                    w_static_nxt  = 1'b1;
                    w_level_nxt   = r_s2;
                end else if (r_fall) begin
                    w_state_nxt   = LOW;
                    w_cnt_hi_nxt  = r_cnt_per;
                    w_cnt_per_nxt = w_cnt_inc;
                end else begin
                    w_cnt_per_nxt = w_cnt_inc;
                end
            end
            LOW: begin
                // A rise coinciding with timeout still publishes.
                if (r_rise) begin
                    w_state_nxt   = HIGH;
                    w_period_nxt  = r_cnt_per;
                    w_high_nxt    = r_cnt_hi;
                    w_valid_nxt   = 1'b1;
                    w_cnt_per_nxt = CNT_ONE;
                end else if (w_timeout) begin
                    w_state_nxt   = WAIT_RISE;
                    w_cnt_per_nxt = '0;
                    w_cnt_hi_nxt  = '0;
                    w_period_nxt  = '0;
                    w_high_nxt    = '0;
                    w_static_nxt  = 1'b1;
                    w_level_nxt   = r_s2;
                end else begin
                    w_cnt_per_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt   = WAIT_RISE;
                w_cnt_per_nxt = '0;
            end
        endcase
    end

    assign period       = r_period;
    assign high_time    = r_high;
    assign meas_valid   = r_valid;
    assign static_flag  = r_static;
    assign static_level = r_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a 16-bit instance (TIMEOUT=1000) and an 8-bit one (TIMEOUT=255).
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_a = 1'b0;
    logic        pwm_b = 1'b0;
    logic [15:0] period_a, high_a;
    logic        valid_a, stat_a, lvl_a;
    logic [7:0]  period_b, high_b;
    logic        valid_b, stat_b, lvl_b;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_e;
    int          strobe_log[$];
    int          rise_log[$];
    int          last_strobe_a = 0;
    int          last_strobe_b = 0;
    int          n_strobe_b = 0;
    int          stat_clr_cyc = -1;
    logic        stat_a_prev = 1'b0;
    bit          armed = 0;
    int          last_h = 0;
    int          last_l = 0;

    pwm_capture #(.CNT_W(16), .TIMEOUT(1000)) dut_a (
        .clk(clk), .rst(rst), .pwm_in(pwm_a),
        .period(period_a), .high_time(high_a), .meas_valid(valid_a),
        .static_flag(stat_a), .static_level(lvl_a)
    );

    pwm_capture #(.CNT_W(8), .TIMEOUT(255)) dut_b (
        .clk(clk), .rst(rst), .pwm_in(pwm_b),
        .period(period_b), .high_time(high_b), .meas_valid(valid_b),
        .static_flag(stat_b), .static_level(lvl_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard side: every strobe must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (valid_a === 1'b1) begin
            last_strobe_a = cyc;
            strobe_log.push_back(cyc);
            check("strobe_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                check("period", 32'(period_a), 32'(exp_e[31:16]));
                check("high_time", 32'(high_a), 32'(exp_e[15:0]));
            end
        end
        if (stat_a_prev && !stat_a) stat_clr_cyc = cyc;
        stat_a_prev = stat_a;
    end

    always @(negedge clk) begin
        if (valid_b === 1'b1) begin
            last_strobe_b = cyc;
            n_strobe_b++;
            check("b_period", 32'(period_b), 32'd200);
            check("b_high_time", 32'(high_b), 32'd20);
        end
    end

    task automatic drive_level(input logic v, input int n);
        pwm_a = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_rise(input int h, input int l);
        if (armed) exp_q.push_back({16'(last_h + last_l), 16'(last_h)});
        armed  = 1;
        last_h = h;
        last_l = l;
        rise_log.push_back(cyc);
    endtask

    task automatic pwm_period(input int h, input int l);
        do_rise(h, l);
        drive_level(1'b1, h);
        drive_level(1'b0, l);
    endtask

    task automatic drive_b(input int h, input int l);
        pwm_b = 1'b1;
        repeat (h) @(posedge clk);
        #1;
        pwm_b = 1'b0;
        repeat (l) @(posedge clk);
        #1;
    endtask

    task automatic wait_flag(input bit sel_b, input int limit, input string tag, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((sel_b ? stat_b : stat_a) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check(tag, 32'(sel_b ? stat_b : stat_a), 32'd1);
        @(posedge clk);
        #1;
    endtask

    int at;
    int n0;
    int n1;

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_period", 32'(period_a), 32'd0);
        check("rst_high", 32'(high_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_static", 32'(stat_a), 32'd0);
        check("rst_level", 32'(lvl_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 30/70 x4: three strobes, 100 apart, first 4 edges after second rise
        strobe_log.delete();
        rise_log.delete();
        repeat (4) pwm_period(30, 70);
        check("t1_strobes", 32'(strobe_log.size()), 32'd3);
        if (strobe_log.size() >= 3 && rise_log.size() >= 2) begin
            check("t1_latency", 32'(strobe_log[0] - rise_log[1]), 32'd4);
            check("t1_gap1", 32'(strobe_log[1] - strobe_log[0]), 32'd100);
            check("t1_gap2", 32'(strobe_log[2] - strobe_log[1]), 32'd100);
        end
        pwm_a = 1'b0;
        wait_flag(1'b0, 1500, "t1_static_seen", at);
        armed = 0;
        check("t1_delay", 32'(at - last_strobe_a), 32'd1000);
        check("t1_level", 32'(lvl_a), 32'd0);

        // duty sweep, then 5 periods of 30/70 and a stuck-low input
        pwm_period(1, 99);
        pwm_period(50, 50);
        pwm_period(99, 1);
        n0 = strobe_log.size();
        repeat (5) pwm_period(30, 70);
        pwm_a = 1'b0;
        wait_flag(1'b0, 1500, "t3_static_seen", at);
        armed = 0;
        check("t3_delay", 32'(at - last_strobe_a), 32'd1000);
        check("t3_level", 32'(lvl_a), 32'd0);
        check("t3_period0", 32'(period_a), 32'd0);
        check("t3_high0", 32'(high_a), 32'd0);
        n1 = strobe_log.size();
        check("t3_strobes", 32'(n1 - n0), 32'd5);
        drive_level(1'b0, 300);
        check("t3_no_strobe", 32'(strobe_log.size()), 32'(n1));

        // stuck-high input, then resume 40/60
        repeat (2) pwm_period(30, 70);
        do_rise(0, 0);
        pwm_a = 1'b1;
        wait_flag(1'b0, 1500, "t4_static_seen", at);
        armed = 0;
        check("t4_delay", 32'(at - last_strobe_a), 32'd1000);
        check("t4_level", 32'(lvl_a), 32'd1);
        check("t4_period0", 32'(period_a), 32'd0);
        check("t4_high0", 32'(high_a), 32'd0);
        strobe_log.delete();
        rise_log.delete();
        stat_clr_cyc = -1;
        drive_level(1'b0, 60);
        repeat (3) pwm_period(40, 60);
        check("t4_static_clr", 32'(stat_a), 32'd0);
        check("t4_strobes", 32'(strobe_log.size()), 32'd2);
        if (strobe_log.size() >= 1 && rise_log.size() >= 1) begin
            check("t4_clr_latency", 32'(stat_clr_cyc - rise_log[0]), 32'd4);
            check("t4_first_strobe", 32'(strobe_log[0] - stat_clr_cyc), 32'd100);
        end

        // reset in the middle of a high phase
        do_rise(40, 60);
        drive_level(1'b1, 10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        pwm_a = 1'b0;
        armed = 0;
        @(negedge clk);
        check("t5_period", 32'(period_a), 32'd0);
        check("t5_high", 32'(high_a), 32'd0);
        check("t5_valid", 32'(valid_a), 32'd0);
        check("t5_static", 32'(stat_a), 32'd0);
        @(posedge clk);
        #1;
        strobe_log.delete();
        drive_level(1'b0, 60);
        repeat (3) pwm_period(40, 60);
        check("t5_strobes", 32'(strobe_log.size()), 32'd2);
        drive_level(1'b0, 20);
        check("q_empty", 32'(exp_q.size()), 32'd0);

        // 8-bit instance: idle since reset must not have timed out
        check("b_no_idle_timeout", 32'(stat_b), 32'd0);
        repeat (3) drive_b(20, 180);
        pwm_b = 1'b0;
        wait_flag(1'b1, 400, "b_static_seen", at);
        check("b_delay", 32'(at - last_strobe_b), 32'd255);
        check("b_period0", 32'(period_b), 32'd0);
        check("b_high0", 32'(high_b), 32'd0);
        check("b_strobes", 32'(n_strobe_b), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator: measures an incoming PWM waveform and reports its period and high time in clk cycles.
- Used for loopback self-test of the LED fade path and for reading external PWM sources (fan tach, RC servo).
- Sits between a board input pin and the status/LED logic; the pin is asynchronous to clk.

Parameters:
- CNT_W, 16, width of the period/high-time counters and outputs.
- TIMEOUT, 65535, cycles without a rising edge before the input is declared static (must be ≤ 2^CNT_W-1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- pwm_in  input  1  asynchronous PWM input.
- period  output  CNT_W  last measured period in clk cycles (rising edge to rising edge).
- high_time  output  CNT_W  last measured high time in clk cycles (rising edge to falling edge).
- meas_valid  output  1  one-cycle strobe; period/high_time updated in the same cycle.
- static_flag  output  1  1 while the input has been constant for ≥ TIMEOUT cycles.
- static_level  output  1  synchronized input level captured when static_flag last rose.

Behaviour:
- Reset (rst=1 at posedge clk) forces the following:
  - period=0, high_time=0, meas_valid=0, static_flag=0, static_level=0.
  - Synchronizer flops cleared to 0; FSM to WAIT_RISE; counters to 0.
- Synchronization: two-flop synchronizer (s1, s2) plus a history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - A pin edge is detected 3 clk edges after it occurs.
- Counters:
  - cnt_per counts cycles since the last rise; cnt_hi latches cnt_per at fall.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - On rise, cnt_per reloads to 1 (the rise cycle is counted as cycle 1 of the next period).
- FSM states:
  - WAIT_RISE: after reset or static; counters idle. On rise go to HIGH with cnt_per=1; no publish (first edge only establishes the phase).
  - HIGH: cnt_per increments each cycle. On fall: cnt_hi <= cnt_per, go to LOW.
  - LOW: cnt_per increments. On rise: publish period <= cnt_per, high_time <= cnt_hi, meas_valid=1 for exactly that one cycle; cnt_per <= 1; go to HIGH.
- Publish latency: period/high_time/meas_valid update on the clk edge following the rise-detect cycle.
- Period accounting: for a steady waveform of H high, L low cycles, period=H+L and high_time=H.
- Timeout: in HIGH or LOW, when cnt_per reaches TIMEOUT without a rise:
  - static_flag <= 1, static_level <= s2, period <= 0, high_time <= 0; meas_valid stays 0.
  - Go to WAIT_RISE.
  - This covers both 0% (stuck low) and 100% (stuck high) duty.
- WAIT_RISE from reset never times out: static_flag stays 0 until the first rise has been seen.
- static_flag clears on the next rise; that rise starts a new measurement and does not publish.
- Saturation: if cnt_per saturates before TIMEOUT (only possible if TIMEOUT > 2^CNT_W-1, which is illegal), the saturated value is reported.
- Simultaneous rise and timeout in the same cycle: rise wins; measurement published, no static.
- Outputs hold their last values between strobes.
- Reset mid-measurement discards the partial count; no strobe is emitted.
- Pulses shorter than 1 clk may be missed; no glitch filter.

Test Plan:
- Reset then pwm_in 30 high / 70 low repeated 4 times (TIMEOUT=1000) -> first rise gives no strobe; 3 strobes with period=100, high_time=30; strobes 100 cycles apart; first strobe 4 clk edges after the 2nd pin rise.
- Duty sweep on 100-cycle period, high = 1, 50, 99 -> high_time = 1, 50, 99; period = 100 each.
- 5 periods then pwm_in held low 1500 cycles (TIMEOUT=1000) -> static_flag=1 and static_level=0 exactly 1000 cycles after the last counted rise; period=0, high_time=0; no meas_valid.
- Same with pwm_in held high -> static_flag=1, static_level=1; resume toggling 40/60 -> static_flag clears on first rise; first strobe one period later with period=100, high_time=40.
- Assert rst for 1 cycle in the middle of a HIGH phase -> all outputs 0 next cycle; next measurement needs two rises; no stale strobe.
- CNT_W=8, TIMEOUT=255; period 200, high 20 -> period=200, high_time=20; a 260-cycle low -> static_flag=1, with no counter wrap observed.
